// File: rtl/johnson_step_sequencer.sv
// Command-driven up/down Johnson-code phase sequencer: accepts "move N steps" commands over
// valid/ready, steps the code with a programmable dwell, and pulses done on completion or abort.
module johnson_step_sequencer #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             step_pulse,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  localparam int unsigned DwW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DwW-1:0] DwellLoad = DwW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [DwW-1:0]   dwell_q, dwell_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             step_pulse_q, step_pulse_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  // A legal Johnson code has at most one boundary between adjacent bits; anything else
  // is recovered to all-zeros on the next step.
  function automatic logic [WIDTH-1:0] next_code(input logic [WIDTH-1:0] cur, input logic up);
    int unsigned flips;
    flips = 0;
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (cur[i] != cur[i+1]) flips++;
    end
    if (flips > 1) return '0;
    if (up) return {cur[WIDTH-2:0], ~cur[WIDTH-1]};
    return {~cur[0], cur[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    steps_d      = steps_q;
    dwell_d      = dwell_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          dir_d   = cmd_dir;
          steps_d = cmd_steps;
          dwell_d = DwellLoad;
          if (cmd_steps == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Abort wins over a step that happens to be due on the same edge.
        if (abort) begin
          state_d   = StDone;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (dwell_q == '0) begin
          out_d        = next_code(out_q, dir_q);
          steps_d      = steps_q - CNT_W'(1);
          step_pulse_d = 1'b1;
          dwell_d      = DwellLoad;
          if (steps_q == CNT_W'(1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          dwell_d = dwell_q - DwW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      out_q        <= '0;
      steps_q      <= '0;
      dwell_q      <= '0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      steps_q      <= steps_d;
      dwell_q      <= dwell_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign out        = out_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Directed bench for johnson_step_sequencer with WIDTH=3, DWELL=2 and hand-computed expectations.
module tb_johnson_step_sequencer;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DWELL = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             step_pulse;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;

  logic [WIDTH-1:0] down_codes [7];
  logic [WIDTH-1:0] exp_out;
  int               n_steps;
  logic             got_done;

  johnson_step_sequencer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .DWELL(DWELL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .out       (out),
    .busy      (busy),
    .step_pulse(step_pulse),
    .done      (done),
    .aborted   (aborted),
    .steps_left(steps_left)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a command for one edge (the transfer edge E0); returns just after E0.
  task automatic issue(input logic dir, input logic [CNT_W-1:0] steps);
    check_eq("issue_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    down_codes = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000, 3'b100};

    // Reset with a command pending: must be dropped.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd5;
    abort     = 1'b0;
    tick();
    tick();
    check_eq("rst_out", out, 0);
    check_eq("rst_steps_left", steps_left, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_aborted", aborted, 0);
    check_eq("rst_step_pulse", step_pulse, 0);
    check_eq("rst_ready", cmd_ready, 1);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_out", out, 0);

    // Up 3 steps: out changes at E0+2/+4/+6, done after E0+6, ready after E0+7.
    issue(1'b1, 8'd3);
    check_eq("up_busy_e0", busy, 1);
    check_eq("up_ready_e0", cmd_ready, 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp_out = (c < 2) ? 3'b000 : (c < 4) ? 3'b001 : (c < 6) ? 3'b011 : 3'b111;
      check_eq("up_out", out, exp_out);
      check_eq("up_step_pulse", step_pulse, (c % 2 == 0) && (c <= 6));
      check_eq("up_done", done, c == 6);
      check_eq("up_aborted", aborted, 0);
      check_eq("up_ready", cmd_ready, c == 7);
    end

    // Down 7 from 000 wraps through the full cycle and ends one past the start.
    do_reset();
    issue(1'b0, 8'd7);
    n_steps  = 0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
      tick();
      if (step_pulse) begin
        if (n_steps < 7) check_eq("down_code", out, down_codes[n_steps]);
        n_steps++;
      end
      if (done) begin
        got_done = 1'b1;
        check_eq("down_aborted", aborted, 0);
      end
    end
    check_eq("down_done_seen", got_done, 1);
    check_eq("down_steps", n_steps, 7);
    check_eq("down_final_out", out, 3'b100);
    check_eq("down_steps_left", steps_left, 0);

    // Abort on the edge where step 3 is due.
    do_reset();
    issue(1'b1, 8'd10);
    repeat (4) tick();
    check_eq("abort_pre_out", out, 3'b011);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_out", out, 3'b011);
    check_eq("abort_steps_left", steps_left, 8);
    check_eq("abort_done", done, 1);
    check_eq("abort_aborted", aborted, 1);
    check_eq("abort_step_pulse", step_pulse, 0);
    tick();
    check_eq("abort_done_clr", done, 0);
    check_eq("abort_aborted_clr", aborted, 0);
    check_eq("abort_ready", cmd_ready, 1);
    check_eq("abort_busy", busy, 0);

    // Zero-step command, with the next command held on cmd_valid while busy.
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = 8'd0;
    tick();
    check_eq("zero_done", done, 1);
    check_eq("zero_aborted", aborted, 0);
    check_eq("zero_out", out, 3'b011);
    check_eq("zero_ready", cmd_ready, 0);
    cmd_steps = 8'd1;
    tick();
    check_eq("held_ready", cmd_ready, 1);
    check_eq("held_done_clr", done, 0);
    check_eq("held_busy", busy, 0);
    tick();
    cmd_valid = 1'b0;
    check_eq("held_busy_run", busy, 1);
    check_eq("held_steps_left", steps_left, 1);
    tick();
    check_eq("held_out_wait", out, 3'b011);
    tick();
    check_eq("held_out", out, 3'b111);
    check_eq("held_step_pulse", step_pulse, 1);
    check_eq("held_done", done, 1);
    check_eq("held_steps_zero", steps_left, 0);
    tick();
    check_eq("held_ready_back", cmd_ready, 1);

    // Reset during a run abandons it silently.
    issue(1'b1, 8'd5);
    tick();
    tick();
    check_eq("midrst_pre_out", out, 3'b110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_out", out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_steps_left", steps_left, 0);
    got_done = 1'b0;
    repeat (4) begin
      tick();
      got_done = got_done | done;
    end
    check_eq("midrst_no_done", got_done, 0);
    issue(1'b1, 8'd1);
    tick();
    tick();
    check_eq("midrst_next_out", out, 3'b001);
    check_eq("midrst_next_done", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/johnson_step_sequencer.md
# johnson_step_sequencer

Command-driven sequencer for the up/down Johnson-code phase counter. It accepts "move N steps up/down" commands over a valid/ready handshake. Each step advances the Johnson code by one, with a programmable dwell of clock cycles between steps. Completion and abort are reported with a one-cycle pulse. It sits between the control logic issuing moves and the phase outputs that feed the Johnson-coded load, such as stepper or multiphase drivers.

## Interface
- WIDTH, 3: Johnson register width; 2*WIDTH legal codes; must be ≥2
- CNT_W, 8: width of step count and remaining-step counter
- DWELL, 4: clock cycles per step; must be ≥1
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; has priority over all other inputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; transfer happens when cmd_valid & cmd_ready at a rising edge
- cmd_dir  in  1  1 = count up, 0 = count down; sampled on transfer
- cmd_steps  in  CNT_W  number of steps; 0 = no-op command; sampled on transfer
- abort  in  1  stop the current command; ignored outside RUN
- out  out  WIDTH  current Johnson code
- busy  out  1  state != IDLE
- step_pulse  out  1  high for the one cycle after each edge that changed out
- done  out  1  one-cycle pulse when a command finishes
- aborted  out  1  valid with done; 1 = command ended by abort
- steps_left  out  CNT_W  remaining steps of the current or last command

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on transfer with cmd_steps != 0:
  - steps_left <= cmd_steps
  - direction is latched
  - dwell counter <= DWELL-1
- IDLE -> DONE on transfer with cmd_steps == 0. out is unchanged and aborted = 0.
- RUN behaviour:
  - The dwell counter decrements each cycle.
  - When it is 0 and abort = 0, a step happens: out advances one code, steps_left decrements, step_pulse is set, and the dwell counter reloads DWELL-1.
  - If that step makes steps_left 0, next state is DONE with aborted = 0.
- RUN with abort = 1 at an edge:
  - Next state is DONE with aborted = 1.
  - No step is taken at that edge, even if one was due.
  - steps_left holds the untaken count.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Johnson update:
  - Up: out <= {out[WIDTH-2:0], ~out[WIDTH-1]}. For WIDTH=3: 000→001→011→111→110→100→000.
  - Down: out <= {~out[0], out[WIDTH-1:1]}. This is the exact reverse sequence.
- Wrap-around is inherent: the codes form a cycle, with no saturation and no error.
- out only ever holds legal Johnson codes. If an illegal code is present (e.g. 010 or 101), the next step forces out to all-zeros.
- Position persists across commands. Only reset clears out.
- cmd_valid in RUN or DONE is not accepted (cmd_ready = 0). The requester must hold the command until it is accepted.

## Timing
- Reset values, visible after the first edge with reset = 1:
  - out = 0, steps_left = 0
  - busy = 0, done = 0, aborted = 0, step_pulse = 0
  - cmd_ready = 1, state IDLE
- A cmd_valid in a reset cycle is dropped.
- Reset asserted mid-command abandons the command without a done pulse. out returns to 0.
- Let E0 be the transfer edge:
  - Step k (1..N) updates out at edge E0 + k·DWELL.
  - done is high in the cycle after edge E0 + N·DWELL.
  - cmd_ready is high again after edge E0 + N·DWELL + 1.
- Back-to-back commands: the minimum spacing between transfer edges is N·DWELL + 2 cycles.
- Zero-step command: done is high in the cycle after E0, and cmd_ready returns after E0+1.
- Abort sampled at edge Ea in RUN: done = aborted = 1 in the cycle after Ea.
- step_pulse and done can be high in the same cycle (last step). aborted never coincides with step_pulse.
- All outputs except cmd_ready are registered. cmd_ready decodes the state register only.

## Test plan
- **Reset:** reset for 2 cycles with cmd_valid = 1 → all outputs at reset values, no transfer, out = 000.
- **Up move:** DWELL = 2, WIDTH = 3, up 3 steps from 000 →
  - out = 001 / 011 / 111 at E0+2 / +4 / +6
  - three step_pulses
  - done = 1 and aborted = 0 in the cycle after E0+6
  - cmd_ready = 1 after E0+7
- **Down wrap:** from 000, down 7 steps → codes 100, 110, 111, 011, 001, 000, 100; final out = 100, steps_left = 0.
- **Abort:** up 10 steps, DWELL = 2, abort asserted for the edge at E0+6 (step due) →
  - out stays 011 (2 steps taken)
  - steps_left = 8
  - done = aborted = 1 for one cycle, then IDLE
- **Zero-step and busy-drop:**
  - cmd_steps = 0 → done pulse in the cycle after E0, out unchanged.
  - A second command presented while busy → not accepted until cmd_ready = 1; it then executes normally.
- **Reset mid-run:** reset at E0+3 during an up 5-step command → out = 000, busy = 0, no done pulse, next command accepted normally.
